// File: rtl/bn128_pkg.sv
// Shared BN128 definitions: field-element widths and the record beat
// sequence used by the multiexp input demultiplexers (G1 and G2 variants).
package bn128_pkg;

    localparam int FE_BITS  = 256;
    localparam int FE2_BITS = 2 * FE_BITS;

    typedef logic [FE_BITS-1:0]  fe_t;
    typedef logic [FE2_BITS-1:0] fe2_t;

    // Position within a (scalar, point) record on the combined input stream.
    typedef enum logic [1:0] {
        ST_SCL = 2'd0,
        ST_X   = 2'd1,
        ST_Y   = 2'd2
    } beat_e;

endpackage

// File: rtl/multiexp_fp2_input_demux_axis_reg_slice.sv
// axis_reg_slice: one-deep registered stream source. A loaded beat is held
// with stable dat/sop/eop until the consumer takes it; a new beat may be
// loaded in the same cycle the held one is taken, so streaming has no bubble.
module axis_reg_slice #(
    parameter int W = 256
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_dat,
    input  logic         i_sop,
    input  logic         i_eop,
    output logic         o_free,
    output logic         o_val,
    output logic [W-1:0] o_dat,
    output logic         o_sop,
    output logic         o_eop,
    input  logic         i_rdy
);

    logic         val_q, val_d;
    logic [W-1:0] dat_q, dat_d;
    logic         sop_q, sop_d;
    logic         eop_q, eop_d;

    // The slot can take a new beat when empty or when the held beat leaves now.
    assign o_free = ~val_q | i_rdy;

    // Next-state: load wins over drain; drain only clears val.
    always_comb begin
        // NOTE: every _d gets its current value first, so no path leaves it unassigned and no latch is inferred.
        val_d = val_q;
        dat_d = dat_q;
        sop_d = sop_q;
        eop_d = eop_q;
        if (i_load) begin
            val_d = 1'b1;
            dat_d = i_dat;
            sop_d = i_sop;
            eop_d = i_eop;
        end else if (i_rdy) begin
            val_d = 1'b0;
        end
    end

    // Output register; reset drops any held beat at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the data register is reset as well, so a stale beat can never leak out after reset.
            val_q <= 1'b0;
            dat_q <= '0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from pre-edge values.
            val_q <= val_d;
            dat_q <= dat_d;
            sop_q <= sop_d;
            eop_q <= eop_d;
        end
    end

    assign o_val = val_q;
    assign o_dat = dat_q;
    assign o_sop = sop_q;
    assign o_eop = eop_q;

endmodule

// File: rtl/multiexp_fp2_input_demux.sv
// multiexp_fp2_input_demux: splits the combined host stream of
// (scalar, x, y) records into a registered scalar stream and a registered
// Fp2 point stream, counting records against the batch size.
// Optional framing check and drain: define MULTIEXP_INPUT_FRAME_CHECK_EN.
module multiexp_fp2_input_demux
    import bn128_pkg::*;
#(
    parameter int SCL_BITS = $bits(fe_t),
    parameter int PNT_BITS = $bits(fe2_t),
    parameter int CNT_BITS = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CNT_BITS-1:0] i_num_in,
    // combined input stream
    input  logic [PNT_BITS-1:0] i_host_dat,
    input  logic                i_host_val,
    input  logic                i_host_sop,
    input  logic                i_host_eop,
    output logic                o_host_rdy,
    // scalar stream
    output logic [SCL_BITS-1:0] o_scl_dat,
    output logic                o_scl_val,
    output logic                o_scl_sop,
    output logic                o_scl_eop,
    input  logic                i_scl_rdy,
    // point stream
    output logic [PNT_BITS-1:0] o_pnt_dat,
    output logic                o_pnt_val,
    output logic                o_pnt_sop,
    output logic                o_pnt_eop,
    input  logic                i_pnt_rdy,
    // batch status
    output logic                o_done,
    output logic [CNT_BITS-1:0] o_cnt
`ifdef MULTIEXP_INPUT_FRAME_CHECK_EN
    ,
    output logic                o_err
`endif
);

    beat_e               state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] num_q;
    logic                done_q;

    logic                scl_free;
    logic                pnt_free;
    logic                first_s;
    logic                last_y;
    logic [CNT_BITS-1:0] eff_num;
    logic                lane_free;
    logic                host_rdy;
    logic                accept;
    logic                take;
    logic                scl_load;
    logic                pnt_load;

`ifdef MULTIEXP_INPUT_FRAME_CHECK_EN
    logic                err_q;
    logic                frame_bad;
`else
    // Input framing flags are deliberately ignored in this build.
    logic                unused_frame;
    assign unused_frame = i_host_sop ^ i_host_eop;
`endif

    // Batch position, ready and accept decode.
    always_comb begin
        first_s   = (state_q == ST_SCL) && (cnt_q == '0);
        // The batch size is latched on the first S beat, so before that the
        // live input decides whether the batch is empty.
        eff_num   = first_s ? i_num_in : num_q;
        last_y    = (state_q == ST_Y) && ((cnt_q + CNT_BITS'(1)) == num_q);
        lane_free = (state_q == ST_SCL) ? scl_free : pnt_free;
`ifdef MULTIEXP_INPUT_FRAME_CHECK_EN
        frame_bad = (i_host_sop != first_s) || (i_host_eop != last_y);
        host_rdy  = err_q || ((eff_num != '0) && lane_free);
        accept    = i_host_val && host_rdy;
        take      = accept && !err_q && !frame_bad;
`else
        host_rdy  = (eff_num != '0) && lane_free;
        accept    = i_host_val && host_rdy;
        take      = accept;
`endif
        scl_load  = take && (state_q == ST_SCL);
        pnt_load  = take && (state_q != ST_SCL);
    end

    assign o_host_rdy = host_rdy;

    // Record FSM, record counter, batch-size latch and done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_SCL;
            cnt_q   <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (take) begin
                case (state_q)
                    ST_SCL: begin
                        if (cnt_q == '0) begin
                            num_q <= i_num_in;
                        end
                        state_q <= ST_X;
                    end
                    ST_X: begin
                        state_q <= ST_Y;
                    end
                    ST_Y: begin
                        state_q <= ST_SCL;
                        if (last_y) begin
                            cnt_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_BITS'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_SCL;
                    end
                endcase
            end
        end
    end

`ifdef MULTIEXP_INPUT_FRAME_CHECK_EN
    // Sticky framing error; once set the input is drained until reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (accept && frame_bad) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`endif

    assign o_done = done_q;
    assign o_cnt  = cnt_q;

    // Scalar lane: every scalar beat closes its own packet.
    axis_reg_slice #(
        .W(SCL_BITS)
    ) u_scl_slice (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (scl_load),
        .i_dat   (i_host_dat[SCL_BITS-1:0]),
        .i_sop   (cnt_q == '0),
        .i_eop   (1'b1),
        .o_free  (scl_free),
        .o_val   (o_scl_val),
        .o_dat   (o_scl_dat),
        .o_sop   (o_scl_sop),
        .o_eop   (o_scl_eop),
        .i_rdy   (i_scl_rdy)
    );

    // Point lane: x opens the two-beat packet, y closes it.
    axis_reg_slice #(
        .W(PNT_BITS)
    ) u_pnt_slice (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (pnt_load),
        .i_dat   (i_host_dat),
        .i_sop   (state_q == ST_X),
        .i_eop   (state_q == ST_Y),
        .o_free  (pnt_free),
        .o_val   (o_pnt_val),
        .o_dat   (o_pnt_dat),
        .o_sop   (o_pnt_sop),
        .o_eop   (o_pnt_eop),
        .i_rdy   (i_pnt_rdy)
    );

endmodule

// File: tb/tb_multiexp_fp2_input_demux.sv
// Scoreboard bench for multiexp_fp2_input_demux: the driver pushes expected
// output beats as it issues records; a negedge monitor pops and compares.
module tb_multiexp_fp2_input_demux;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [63:0]  num_in = '0;
    logic [511:0] host_dat = '0;
    logic         host_val = 1'b0, host_sop = 1'b0, host_eop = 1'b0;
    logic         host_rdy;
    logic [255:0] scl_dat;
    logic         scl_val, scl_sop, scl_eop;
    logic         scl_rdy = 1'b1;
    logic [511:0] pnt_dat;
    logic         pnt_val, pnt_sop, pnt_eop;
    logic         pnt_rdy = 1'b1;
    logic         done;
    logic [63:0]  cnt;
`ifdef MULTIEXP_INPUT_FRAME_CHECK_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    multiexp_fp2_input_demux dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_num_in   (num_in),
        .i_host_dat (host_dat),
        .i_host_val (host_val),
        .i_host_sop (host_sop),
        .i_host_eop (host_eop),
        .o_host_rdy (host_rdy),
        .o_scl_dat  (scl_dat),
        .o_scl_val  (scl_val),
        .o_scl_sop  (scl_sop),
        .o_scl_eop  (scl_eop),
        .i_scl_rdy  (scl_rdy),
        .o_pnt_dat  (pnt_dat),
        .o_pnt_val  (pnt_val),
        .o_pnt_sop  (pnt_sop),
        .o_pnt_eop  (pnt_eop),
        .i_pnt_rdy  (pnt_rdy),
        .o_done     (done),
        .o_cnt      (cnt)
`ifdef MULTIEXP_INPUT_FRAME_CHECK_EN
        ,
        .o_err      (err)
`endif
    );

    typedef struct {
        logic [511:0] dat;
        logic         sop;
        logic         eop;
        logic         chk_cnt;
        logic [63:0]  cnt;
    } exp_t;

    exp_t scl_q[$];
    exp_t pnt_q[$];
    exp_t e_mon;

    int n_vec = 0, n_fail = 0;
    int cyc = 0, n_acc = 0, first_acc = 0, last_acc = 0;
    int n_done = 0, exp_done = 0;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: event seen/missing, required otherwise", name);
    endtask

    function automatic logic [511:0] s_of(input int b, input int r);
        return {256'hABCD_0000 + 256'(b), 256'(100 * b + r + 7)};
    endfunction
    function automatic logic [511:0] x_of(input int b, input int r);
        return {256'(2000 + 100 * b + r), 256'(1000 + 100 * b + r)};
    endfunction
    function automatic logic [511:0] y_of(input int b, input int r);
        return {256'(4000 + 100 * b + r), 256'(3000 + 100 * b + r)};
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every transfer seen on an output must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (host_val && host_rdy) begin
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
            end
            if (scl_val && scl_rdy) begin
                if (scl_q.size() == 0) fail("scl_unexpected");
                else begin
                    e_mon = scl_q.pop_front();
                    check("scl_dat", scl_dat, e_mon.dat[255:0]);
                    check("scl_sop_eop", {scl_sop, scl_eop}, {e_mon.sop, e_mon.eop});
                end
            end
            if (pnt_val && pnt_rdy) begin
                if (pnt_q.size() == 0) fail("pnt_unexpected");
                else begin
                    e_mon = pnt_q.pop_front();
                    check("pnt_dat", pnt_dat, e_mon.dat);
                    check("pnt_sop_eop", {pnt_sop, pnt_eop}, {e_mon.sop, e_mon.eop});
                    if (e_mon.chk_cnt) check("cnt_at_y", cnt, e_mon.cnt);
                end
            end
            if (done) begin
                n_done++;
                check("done_cnt_zero", cnt, 0);
                check("done_with_y", {pnt_val, pnt_eop}, 2'b11);
            end
        end
    end

    // Present one beat and return just after the edge that accepted it.
    task automatic send(input logic [511:0] d, input logic sop, input logic eop);
        bit ok = 0;
        host_dat = d;
        host_sop = sop;
        host_eop = eop;
        host_val = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (host_rdy === 1'b1) ok = 1;
        end
        if (!ok) fail("accept_timeout");
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_record(input logic [511:0] s, input logic [511:0] x,
                               input logic [511:0] y, input int r, input int n);
        scl_q.push_back('{dat: {256'd0, s[255:0]}, sop: (r == 0), eop: 1'b1, chk_cnt: 1'b0, cnt: '0});
        pnt_q.push_back('{dat: x, sop: 1'b1, eop: 1'b0, chk_cnt: 1'b0, cnt: '0});
        pnt_q.push_back('{dat: y, sop: 1'b0, eop: 1'b1, chk_cnt: 1'b1,
                          cnt: (r + 1 == n) ? 64'd0 : 64'(r + 1)});
        if (r + 1 == n) exp_done++;
    endtask

    task automatic batch(input int b, input int n);
        for (int r = 0; r < n; r++) begin
            push_record(s_of(b, r), x_of(b, r), y_of(b, r), r, n);
            send(s_of(b, r), r == 0, 1'b0);
            send(x_of(b, r), 1'b0, 1'b0);
            send(y_of(b, r), 1'b0, r + 1 == n);
        end
        host_val = 1'b0;
    endtask

    task automatic stall_x_of_record2();
        bit found = 0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (host_val && host_rdy && host_dat == x_of(2, 1)) found = 1;
        end
        if (!found) fail("stall_trigger_timeout");
        else begin
            @(posedge clk);
            #1 pnt_rdy = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check("stall_host_rdy", host_rdy, 1'b0);
                check("stall_x_held", {pnt_val, pnt_sop, pnt_dat}, {2'b11, x_of(2, 1)});
            end
            @(posedge clk);
            #1 pnt_rdy = 1'b1;
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_vals", {scl_val, pnt_val, scl_sop, scl_eop, pnt_sop, pnt_eop, done}, 7'd0);
        check("rst_cnt", cnt, 0);
        check("rst_pnt_dat", pnt_dat, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single record with hand-computed beats and one-cycle latency
        num_in = 64'd1;
        push_record(512'h5, {256'd2, 256'd1}, {256'd4, 256'd3}, 0, 1);
        send(512'h5, 1'b1, 1'b0);
        check("t1_scl_lat", {scl_val, scl_sop, scl_eop, scl_dat}, {3'b111, 256'h5});
        send({256'd2, 256'd1}, 1'b0, 1'b0);
        check("t1_x_lat", {pnt_val, pnt_sop, pnt_dat}, {2'b11, 256'd2, 256'd1});
        send({256'd4, 256'd3}, 1'b0, 1'b1);
        host_val = 1'b0;
        check("t1_y_lat", {pnt_val, pnt_eop, pnt_dat}, {2'b11, 256'd4, 256'd3});
        check("t1_done", {done, cnt}, {1'b1, 64'd0});
        repeat (3) @(posedge clk);
        #1;

        // Four records back to back: 12 accepts in 12 cycles
        n_acc = 0;
        num_in = 64'd4;
        batch(1, 4);
        check("t2_accepts", n_acc, 12);
        check("t2_span", last_acc - first_acc, 11);
        repeat (3) @(posedge clk);
        #1;

        // Point consumer stalls 5 cycles on X of record 2
        fork
            batch(2, 4);
            stall_x_of_record2();
        join
        repeat (3) @(posedge clk);
        #1;

        // Empty batch: input never ready, nothing produced
        num_in = 64'd0;
        host_dat = s_of(9, 0);
        host_sop = 1'b1;
        host_eop = 1'b0;
        host_val = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("empty_rdy", host_rdy, 1'b0);
            check("empty_no_out", {scl_val, pnt_val}, 2'b00);
        end
        @(posedge clk);
        #1 host_val = 1'b0;

        // Reset while in ST_Y with X held on the point output
        num_in = 64'd2;
        pnt_rdy = 1'b0;
        scl_q.push_back('{dat: {256'd0, s_of(4, 0)}, sop: 1'b1, eop: 1'b1, chk_cnt: 1'b0, cnt: '0});
        send(s_of(4, 0), 1'b1, 1'b0);
        send(x_of(4, 0), 1'b0, 1'b0);
        host_val = 1'b0;
        @(negedge clk);
        check("rst_pre_x_held", {pnt_val, pnt_dat}, {1'b1, x_of(4, 0)});
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_vals", {scl_val, pnt_val, done}, 3'b000);
        check("rst_async_cnt", cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pnt_rdy = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {scl_val, pnt_val}, 2'b00);
        @(posedge clk);
        #1;
        batch(5, 2);
        repeat (3) @(posedge clk);
        #1;

`ifdef MULTIEXP_INPUT_FRAME_CHECK_EN
        // Wrong eop on Y of record 1: error, beat dropped, rest drained
        num_in = 64'd2;
        scl_q.push_back('{dat: {256'd0, s_of(6, 0)}, sop: 1'b1, eop: 1'b1, chk_cnt: 1'b0, cnt: '0});
        pnt_q.push_back('{dat: x_of(6, 0), sop: 1'b1, eop: 1'b0, chk_cnt: 1'b0, cnt: '0});
        send(s_of(6, 0), 1'b1, 1'b0);
        send(x_of(6, 0), 1'b0, 1'b0);
        send(y_of(6, 0), 1'b0, 1'b1);
        host_val = 1'b0;
        check("frame_err_set", err, 1'b1);
        send(s_of(6, 1), 1'b0, 1'b0);
        send(x_of(6, 1), 1'b0, 1'b0);
        send(y_of(6, 1), 1'b0, 1'b1);
        host_val = 1'b0;
        @(negedge clk);
        check("frame_drain_no_out", {scl_val, pnt_val}, 2'b00);
        check("frame_err_sticky", err, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("frame_err_rst", err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
`endif

        // Drain check
        for (int k = 0; k < 50 && (scl_q.size() != 0 || pnt_q.size() != 0); k++) @(posedge clk);
        #1;
        check("scl_q_left", scl_q.size(), 0);
        check("pnt_q_left", pnt_q.size(), 0);
        check("done_pulses", n_done, exp_done);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
